// File: rtl/psum_threshold_unit_pkg.sv
// Shared PE-array schedule constants: frame length derivation, psum slot origin,
// and the frame-counter and channel-index widths.
package psum_threshold_unit_pkg;

  localparam int unsigned FC_W           = 7;
  localparam int unsigned CH_W           = 4;
  localparam int unsigned O_CH_DEF       = 9;
  localparam int unsigned ROW_LENGTH_DEF = 7;
  localparam int unsigned PSUM_SLOT0_DEF = 2;

  function automatic int unsigned frame_len(input int unsigned o_ch,
                                            input int unsigned row_len);
    return o_ch * row_len + row_len;
  endfunction

  localparam int unsigned FRAME_LEN_DEF = frame_len(O_CH_DEF, ROW_LENGTH_DEF);

  typedef logic [FC_W-1:0] fc_t;
  typedef logic [CH_W-1:0] ch_t;

endpackage

// File: rtl/psum_acc_lane.sv
// One output channel: saturating partial-sum accumulator, threshold register
// and the binarized result bit.
module psum_acc_lane #(
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned ACC_WIDTH = 18
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 slot_i,
  input  logic                 clear_i,
  input  logic                 last_i,
  input  logic [WIDTH-1:0]     psum_i,
  input  logic                 thr_we_i,
  input  logic [ACC_WIDTH-1:0] thr_data_i,
  output logic                 res_next_o
);

  localparam int unsigned SW = ACC_WIDTH + 1;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] thr_q, thr_d;
  logic [ACC_WIDTH-1:0] base, sum;
  logic [SW-1:0]        raw;
  logic                 res_q, res_d;

  always_comb begin
    base  = clear_i ? '0 : acc_q;
    raw   = {1'b0, base} + SW'(psum_i);
    sum   = raw[ACC_WIDTH] ? '1 : raw[ACC_WIDTH-1:0];
    acc_d = slot_i ? sum : acc_q;
    // thr_q is the pre-write value, so a same-cycle write only affects later slots
    res_d = (slot_i && last_i) ? (sum >= thr_q) : res_q;
    thr_d = thr_we_i ? thr_data_i : thr_q;
  end

  // Exposing the next value lets the top commit the final channel in its own slot cycle.
  assign res_next_o = res_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      thr_q <= '0;
      res_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      thr_q <= thr_d;
      res_q <= res_d;
    end
  end

endmodule

// File: rtl/psum_threshold_unit.sv
// Tracks the PE array frame, accumulates per-channel psums over several passes,
// and hands the binarized channel word downstream over valid/ready.
module psum_threshold_unit
  import psum_threshold_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 14,
  parameter int unsigned O_CH       = O_CH_DEF,
  parameter int unsigned ROW_LENGTH = ROW_LENGTH_DEF,
  parameter int unsigned FRAME_LEN  = frame_len(O_CH, ROW_LENGTH),
  parameter int unsigned PSUM_SLOT0 = PSUM_SLOT0_DEF,
  parameter int unsigned ACC_PASSES = 4,
  parameter int unsigned ACC_WIDTH  = 18
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     psum_in,
  input  logic                 thr_we,
  input  logic [CH_W-1:0]      thr_addr,
  input  logic [ACC_WIDTH-1:0] thr_data,
  output logic [O_CH-1:0]      act_out,
  output logic                 act_valid,
  input  logic                 act_ready,
  output logic                 overflow_out
);

  localparam int unsigned PASS_W = (ACC_PASSES > 1) ? $clog2(ACC_PASSES) : 1;
  localparam logic [PASS_W-1:0] LAST_P = PASS_W'(ACC_PASSES - 1);

  fc_t               fc_q, fc_d;
  logic              first_q, first_d;
  logic [PASS_W-1:0] p_q, p_d;
  logic [O_CH-1:0]   out_q, out_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [O_CH-1:0]   res_next;
  logic              frame_end, last_pass, commit;

  assign frame_end = (fc_q == fc_t'(FRAME_LEN - 1));
  assign last_pass = (p_q == LAST_P);
  assign commit    = !first_q && last_pass && (fc_q == fc_t'(PSUM_SLOT0 + O_CH - 1));

  for (genvar c = 0; c < O_CH; c++) begin : g_lane
    psum_acc_lane #(
      .WIDTH    (WIDTH),
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk_i     (clk_in),
      .rst_ni    (rst_in),
      .slot_i    (!first_q && (fc_q == fc_t'(PSUM_SLOT0 + c))),
      .clear_i   (p_q == '0),
      .last_i    (last_pass),
      .psum_i    (psum_in),
      .thr_we_i  (thr_we && (thr_addr == ch_t'(c))),
      .thr_data_i(thr_data),
      .res_next_o(res_next[c])
    );
  end

  always_comb begin
    fc_d    = frame_end ? '0 : fc_q + fc_t'(1);
    first_d = frame_end ? 1'b0 : first_q;
    p_d     = p_q;
    if (frame_end && !first_q) begin
      p_d = last_pass ? '0 : p_q + PASS_W'(1);
    end
    out_d   = commit ? res_next : out_q;
    valid_d = valid_q;
    if (commit) begin
      valid_d = 1'b1;
    end else if (valid_q && act_ready) begin
      valid_d = 1'b0;
    end
    ovf_d = ovf_q | (commit & valid_q & ~act_ready);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fc_q    <= '0;
      first_q <= 1'b1;
      p_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      fc_q    <= fc_d;
      first_q <= first_d;
      p_q     <= p_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign act_out      = out_q;
  assign act_valid    = valid_q;
  assign overflow_out = ovf_q;

endmodule
